pool_relu_2x2: RTL and testbench

POOL_RELU_2X2 -- requirements
Module: pool_relu_2x2

---
 rtl/pool_relu_2x2.sv | 139 +++++++++++++
 tb/tb_pool_relu_2x2.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pool_relu_2x2.sv
// ============================================================================
// pool_relu_2x2 : streaming 2x2 signed max-pool with optional ReLU
//                 (define POOL_RELU_EN to clamp negative samples to zero)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module pool_relu_2x2 #(
   parameter int DATA_W  = 10,
   parameter int ROW_LEN = 8
) (
   input  logic              clk_i,
   input  logic              nreset_i,
   input  logic              start_i,
   input  logic              px_rdy_i,
   input  logic [DATA_W-1:0] in_px_i,
   output logic [DATA_W-1:0] out_px_o,
   output logic              px_rdy_o,
   output logic              busy_o
);

   localparam int c_col_w = (ROW_LEN > 2) ? $clog2(ROW_LEN) : 1;
   localparam int c_half  = ROW_LEN / 2;
   localparam int c_idx_w = (c_half > 1) ? $clog2(c_half) : 1;

   localparam logic [1:0] c_idle     = 2'd0;
   localparam logic [1:0] c_even_row = 2'd1;
   localparam logic [1:0] c_odd_row  = 2'd2;

   if (((ROW_LEN % 2) != 0) || (ROW_LEN < 2)) begin : g_row_len_check
      $error("pool_relu_2x2: ROW_LEN must be even and >= 2");
   end

   logic [1:0]               state_q, state_d;
   logic [c_col_w-1:0]       col_q, col_d;
   logic signed [DATA_W-1:0] pair_q, pair_d;
   logic signed [DATA_W-1:0] out_q, out_d;
   logic                     rdy_q, rdy_d;
   logic signed [DATA_W-1:0] buf_q [c_half];

   logic                     w_acc;
   logic                     w_last_col;
   logic                     w_odd_col;
   logic [c_idx_w-1:0]       w_idx;
   logic signed [DATA_W-1:0] w_px;
   logic signed [DATA_W-1:0] w_pair_max;
   logic signed [DATA_W-1:0] w_buf_rd;
   logic signed [DATA_W-1:0] w_max3;

   // Preprocess: ReLU clamp or straight pass-through
`ifdef POOL_RELU_EN
   assign w_px = in_px_i[DATA_W-1] ? '0 : $signed(in_px_i);
`else
   assign w_px = $signed(in_px_i);
`endif

   assign w_acc      = px_rdy_i && start_i && (state_q != c_idle);
   assign w_last_col = (col_q == c_col_w'(ROW_LEN - 1));
   assign w_odd_col  = col_q[0];
   assign w_idx      = c_idx_w'(col_q >> 1);
   assign w_buf_rd   = buf_q[w_idx];
   assign w_pair_max = (w_px > pair_q) ? w_px : pair_q;
   assign w_max3     = (w_buf_rd > w_pair_max) ? w_buf_rd : w_pair_max;

   // State register
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q <= c_idle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (!start_i) begin
         state_d = c_idle;
      end else begin
         case (state_q)
            c_idle:     state_d = c_even_row;
            c_even_row: if (w_acc && w_last_col) state_d = c_odd_row;
            c_odd_row:  if (w_acc && w_last_col) state_d = c_even_row;
            default:    state_d = c_idle;
         endcase
      end
   end

   // Output logic
   always_comb begin
      busy_o   = (state_q != c_idle);
      out_px_o = out_q;
      px_rdy_o = rdy_q;
   end

   // Datapath next values
   always_comb begin
      col_d  = col_q;
      pair_d = pair_q;
      rdy_d  = 1'b0;
      out_d  = out_q;
      if (!start_i) begin
         col_d = '0;
      end else if (w_acc) begin
         col_d = w_last_col ? '0 : col_q + 1'b1;
         if (!w_odd_col) begin
            pair_d = w_px;
         end else if (state_q == c_odd_row) begin
            rdy_d = 1'b1;
            out_d = w_max3;
         end
      end
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         col_q  <= '0;
         pair_q <= '0;
         out_q  <= '0;
         rdy_q  <= 1'b0;
      end else begin
         col_q  <= col_d;
         pair_q <= pair_d;
         out_q  <= out_d;
         rdy_q  <= rdy_d;
      end
   end

   // Every entry is rewritten in an even row before an odd row reads it,
   // so the buffer needs no reset.
   always_ff @(posedge clk_i) begin
      if (w_acc && w_odd_col && (state_q == c_even_row)) begin
         buf_q[w_idx] <= w_pair_max;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pool_relu_2x2.sv
// ============================================================================
// tb_pool_relu_2x2 : directed self-checking bench for pool_relu_2x2 (ROW_LEN=4)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_pool_relu_2x2;

   localparam int DATA_W  = 10;
   localparam int ROW_LEN = 4;

   logic              clk_i;
   logic              nreset_i;
   logic              start_i;
   logic              px_rdy_i;
   logic [DATA_W-1:0] in_px_i;
   logic [DATA_W-1:0] out_px_o;
   logic              px_rdy_o;
   logic              busy_o;

   int n_tests;
   int n_fail;
   int n_out;
   int n0;

   pool_relu_2x2 #(
      .DATA_W  (DATA_W),
      .ROW_LEN (ROW_LEN)
   ) dut (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .start_i  (start_i),
      .px_rdy_i (px_rdy_i),
      .in_px_i  (in_px_i),
      .out_px_o (out_px_o),
      .px_rdy_o (px_rdy_o),
      .busy_o   (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (px_rdy_o) n_out++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic feed(input int v);
      logic [31:0] tmp;
      tmp      = v;
      px_rdy_i = 1'b1;
      in_px_i  = tmp[DATA_W-1:0];
      tick();
      px_rdy_i = 1'b0;
   endtask

   function automatic int out_val();
      return int'($signed(out_px_o));
   endfunction

   // Rows [1,2,3,4],[5,6,7,8]: outputs 6 then 8, each right after its last sample
   task automatic frame(input string tag, input int gap_max);
      int base;
      base = n_out;
      for (int i = 1; i <= 8; i++) begin
         feed(i);
         if (i == 6) begin
            check({tag, "_rdy6"}, int'(px_rdy_o), 1);
            check({tag, "_out6"}, out_val(), 6);
         end
         if (i == 7) begin
            check({tag, "_rdy7"}, int'(px_rdy_o), 0);
            check({tag, "_hold6"}, out_val(), 6);
         end
         if (i == 8) begin
            check({tag, "_rdy8"}, int'(px_rdy_o), 1);
            check({tag, "_out8"}, out_val(), 8);
         end
         repeat ($urandom_range(0, gap_max)) tick();
      end
      tick();
      #1;
      check({tag, "_count"}, n_out - base, 2);
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      n_out    = 0;
      nreset_i = 1'b0;
      start_i  = 1'b0;
      px_rdy_i = 1'b0;
      in_px_i  = '0;

      #3;
      check("reset_out", out_val(), 0);
      check("reset_rdy", int'(px_rdy_o), 0);
      check("reset_busy", int'(busy_o), 0);
      tick();
      nreset_i = 1'b1;
      tick();
      check("idle_busy", int'(busy_o), 0);

      // Basic frame
      start_i = 1'b1;
      tick();
      check("start_busy", int'(busy_o), 1);
      frame("basic", 0);
      start_i = 1'b0;
      tick();
      check("stop_busy", int'(busy_o), 0);

      // All -1.0 block: ReLU clamps to 0, plain max-pool keeps -64
      start_i = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) feed(-64);
      check("neg_rdy", int'(px_rdy_o), 1);
`ifdef POOL_RELU_EN
      check("neg_out", out_val(), 0);
`else
      check("neg_out", out_val(), -64);
`endif
      start_i = 1'b0;
      tick();

      // Three rows then stop: trailing row produces nothing
      start_i = 1'b1;
      tick();
      n0 = n_out;
      for (int i = 1; i <= 12; i++) feed(i);
      start_i = 1'b0;
      tick();
      check("tail_busy", int'(busy_o), 0);
      #1;
      check("tail_count", n_out - n0, 2);
      check("tail_hold", out_val(), 8);

      // Random gaps between strobes
      start_i = 1'b1;
      tick();
      frame("gaps", 5);
      start_i = 1'b0;
      tick();

      // Strobe coinciding with start_i falling is dropped
      start_i = 1'b1;
      tick();
      feed(1);
      feed(2);
      feed(3);
      n0       = n_out;
      start_i  = 1'b0;
      px_rdy_i = 1'b1;
      in_px_i  = 10'd100;
      tick();
      px_rdy_i = 1'b0;
      check("drop_busy", int'(busy_o), 0);
      tick();
      #1;
      check("drop_count", n_out - n0, 0);
      check("drop_hold", out_val(), 8);
      start_i = 1'b1;
      tick();
      frame("after_drop", 0);

      // Async reset mid-frame after row 0 col 2
      feed(1);
      feed(2);
      feed(3);
      #2;
      nreset_i = 1'b0;
      start_i  = 1'b0;
      #1;
      check("rst_out", out_val(), 0);
      check("rst_rdy", int'(px_rdy_o), 0);
      check("rst_busy", int'(busy_o), 0);
      tick();
      nreset_i = 1'b1;
      tick();
      n0 = n_out;
      for (int i = 1; i <= 8; i++) feed(i + 20);
      tick();
      #1;
      check("rst_no_out", n_out - n0, 0);
      check("rst_idle", int'(busy_o), 0);
      start_i = 1'b1;
      tick();
      frame("after_rst", 0);
      start_i = 1'b0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
